// File: rtl/general_multiplier.sv
// Sequential signed 8x8 radix-2 Booth multiplier.
// Exposes the FSM state and the raw {A,Q,Q-1} register.
module general_multiplier (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  DP_B,
  input  logic [7:0]  DP_Q,
  output logic [2:0]  ready,
  output logic [16:0] Producto
);

  typedef enum logic [2:0] {
    INIT  = 3'b000,
    EVAL  = 3'b001,
    SHIFT = 3'b010,
    CHECK = 3'b011,
    DONE  = 3'b100
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] a_q, a_d;
  logic [7:0] m_q, m_d;
  logic [7:0] q_q, q_d;
  logic       qm1_q, qm1_d;
  logic [3:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      a_q     <= 8'h00;
      m_q     <= 8'h00;
      q_q     <= 8'h00;
      qm1_q   <= 1'b0;
      cnt_q   <= 4'd8;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      m_q     <= m_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    m_d     = m_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      INIT: begin
        a_d     = 8'h00;
        m_d     = DP_B;
        q_d     = DP_Q;
        qm1_d   = 1'b0;
        cnt_d   = 4'd8;
        state_d = EVAL;
      end
      EVAL: begin
        unique case ({q_q[0], qm1_q})
          2'b10:   a_d = a_q - m_q;
          2'b01:   a_d = a_q + m_q;
          default: a_d = a_q;
        endcase
        state_d = SHIFT;
      end
      SHIFT: begin
        // arithmetic shift: A[7] refills the top
        {a_d, q_d, qm1_d} = {a_q[7], a_q, q_q};
        cnt_d   = cnt_q - 4'd1;
        state_d = CHECK;
      end
      CHECK: begin
        state_d = (cnt_q == 4'd0) ? DONE : EVAL;
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = INIT;
      end
    endcase
  end

  assign ready    = state_q;
  assign Producto = {a_q, q_q, qm1_q};

endmodule

// File: tb/tb_general_multiplier.sv
// Randomized bench for general_multiplier with a cycle-level
// behavioural model of state sequence and product.
module tb_general_multiplier;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  DP_B = 8'h00;
  logic [7:0]  DP_Q = 8'h00;
  logic [2:0]  ready;
  logic [16:0] Producto;

  int checks = 0;
  int errors = 0;

  general_multiplier dut (
    .clk      (clk),
    .rst      (rst),
    .DP_B     (DP_B),
    .DP_Q     (DP_Q),
    .ready    (ready),
    .Producto (Producto)
  );

  always #5 clk = ~clk;

  // Model: edges since reset release and operands captured at edge 1
  int         k = 0;
  bit         valid = 1'b0;
  logic [7:0] mb = 8'h00;
  logic [7:0] mq = 8'h00;

  always @(posedge clk) begin
    if (rst) begin
      k     = 0;
      mb    = 8'h00;
      mq    = 8'h00;
      valid = 1'b1;
    end else begin
      if (k < 100000) k = k + 1;
      if (k == 1) begin
        mb = DP_B;
        mq = DP_Q;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] exp_ready(input int n);
    if (n == 0) return 3'b000;
    if (n >= 25) return 3'b100;
    return 3'((n - 1) % 3 + 1);
  endfunction

  function automatic logic [16:0] exp_final(input logic [7:0] b,
                                            input logic [7:0] q);
    logic signed [7:0]  sb;
    logic signed [7:0]  sq;
    logic signed [15:0] p;
    sb = b;
    sq = q;
    p  = sb * sq;
    // last bit shifted out of Q is the multiplier sign bit
    return {p, q[7]};
  endfunction

  always @(negedge clk) begin
    if (valid) begin
      chk("ready", 32'(ready), 32'(exp_ready(k)));
      if (k == 0)
        chk("reset_producto", 32'(Producto), 32'h0);
      else if (k == 1)
        chk("loaded", 32'(Producto), 32'({8'h00, mq, 1'b0}));
      else if (k >= 25 && mb != 8'h80)
        chk("product", 32'(Producto), 32'(exp_final(mb, mq)));
    end
  end

  task automatic do_reset(input int cycles);
    @(posedge clk);
    #2 rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic run(input logic [7:0] b, input logic [7:0] q,
                     input bit scramble);
    do_reset(1);
    DP_B = b;
    DP_Q = q;
    @(posedge clk);
    if (scramble) begin
      for (int i = 0; i < 8; i++) begin
        #2;
        DP_B = 8'($urandom);
        DP_Q = 8'($urandom);
        @(posedge clk);
      end
      repeat (20) @(posedge clk);
    end else begin
      repeat (27) @(posedge clk);
    end
    #2;
  endtask

  initial begin
    logic [7:0] rb;
    logic [7:0] rq;

    do_reset(3);
    run(8'h17, 8'h11, 1'b0);
    chk("lit_23x17", 32'(Producto), 32'h0030E);
    chk("lit_done", 32'(ready), 32'h4);

    run(8'h05, 8'hFD, 1'b0);
    chk("lit_5xm3", 32'(Producto[16:1]), 32'hFFF1);

    run(8'hFF, 8'hFF, 1'b0);
    chk("lit_m1xm1", 32'(Producto[16:1]), 32'h0001);

    run(8'h7F, 8'h80, 1'b0);
    chk("lit_127xm128", 32'(Producto[16:1]), 32'hC080);

    run(8'h00, 8'h5A, 1'b0);
    chk("lit_zero", 32'(Producto), 32'h0);

    run(8'h17, 8'h11, 1'b1);
    chk("lit_scramble", 32'(Producto), 32'h0030E);

    // reset in SHIFT of iteration 4, then rerun 23x17
    do_reset(1);
    DP_B = 8'h6B;
    DP_Q = 8'hC4;
    repeat (11) @(posedge clk);
    #2;
    chk("mid_shift", 32'(ready), 32'h2);
    rst = 1'b1;
    @(posedge clk);
    #2;
    chk("mid_rst_ready", 32'(ready), 32'h0);
    chk("mid_rst_prod", 32'(Producto), 32'h0);
    rst  = 1'b0;
    DP_B = 8'h17;
    DP_Q = 8'h11;
    repeat (25) @(posedge clk);
    #2;
    chk("mid_rerun", 32'(Producto), 32'h0030E);
    chk("mid_rerun_done", 32'(ready), 32'h4);

    for (int n = 0; n < 24; n++) begin
      rb = 8'($urandom);
      if (rb == 8'h80) rb = 8'h81;
      rq = 8'($urandom);
      run(rb, rq, n[0]);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
